// File: rtl/cdc_pkg.sv
// Shared state encoding for the toggle req/ack CDC handshake blocks.
package cdc_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'b00;
  localparam logic [1:0] ENC_SETUP = 2'b01;
  localparam logic [1:0] ENC_WAIT  = 2'b10;

  // Prefixed so the SETUP literal cannot collide with the SETUP parameter of importers.
  typedef enum logic [1:0] {
    S_IDLE  = ENC_IDLE,
    S_SETUP = ENC_SETUP,
    S_WAIT  = ENC_WAIT
  } state_t;

endpackage

// File: rtl/sync2pa.sv
// Two-flop synchronizer, async active-low reset to R; 2-cycle latency, no backpressure.
module sync2pa #(
  parameter bit R = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= R;
      q    <= R;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdc_hs_tx.sv
// Toggle-handshake CDC source: req toggles SETUP cycles after accept, done ~3 cycles after ack.
// Backpressure: in_ready stays low from accept until done; one word in flight at a time.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int W       = 8,
  parameter int SETUP   = 2,
  parameter int TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic [W-1:0] tx_data,
  output logic         tx_req,
  input  logic         tx_ack,
  output logic         done,
  output logic         err,
  input  logic         err_clr
);

  localparam int CNT_W = $clog2(SETUP + 1);
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETUP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT > 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic             ack_s;
  logic             match;
  logic             proto_err;
  logic             tmo_err;

  sync2pa #(.R(1'b0)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tx_ack),
    .q     (ack_s)
  );

  assign match     = (ack_s == tx_req);
  // Outside WAIT the levels must agree; a mismatch means the far side toggled on its own.
  assign proto_err = (state != S_WAIT) && !match;
  assign tmo_err   = TMO_EN && (state == S_WAIT) && !match && (tmo == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      tx_data  <= '0;
      tx_req   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
      tmo      <= '0;
    end else begin
      done <= 1'b0;
      if (err_clr)
        err <= 1'b0;
      else if (proto_err || tmo_err)
        err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            tx_data  <= in_data;
            in_ready <= 1'b0;
            cnt      <= '0;
            state    <= S_SETUP;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            tx_req <= ~tx_req;
            tmo    <= '0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Timeout only flags; the word stays on tx_data until the ack arrives.
          if (match) begin
            done     <= 1'b1;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end else if (tmo != '1) begin
            tmo <= tmo + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx with W=8, SETUP=2, TIMEOUT=8; destination ack driven by hand.
module tb_cdc_hs_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       tx_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  cdc_hs_tx #(.W(8), .SETUP(2), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_ack   (tx_ack),
    .done     (done),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; tx_ack = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_ack = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL rst_tx_req: got %b want 0", tx_req); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    repeat (2) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_held_in_ready: got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_in_ready: got %b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_word();
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL sw_tx_data: got %h want a5", tx_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sw_in_ready_low: got %b want 0", in_ready); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL sw_req_t0: got %b want 0", tx_req); end
    tick();
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL sw_req_t1: got %b want 0", tx_req); end
    tick();
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL sw_req_t2: got %b want 1", tx_req); end
    tick();
    tx_ack = 1'b1;
    tick(); tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sw_done_early: got %b want 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sw_done: got %b want 1", done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sw_in_ready_back: got %b want 1", in_ready); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL sw_tx_data_hold: got %h want a5", tx_data); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sw_done_pulse_len: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sw_err: got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    int         acc_idx;
    int         dones;
    int         toggles;
    int         bad_hold;
    logic       prev_req;
    logic       holding;
    logic       acc;
    logic [7:0] held;
    words = '{8'h01, 8'h02, 8'h03, 8'h04};
    acc_idx = 0; dones = 0; toggles = 0; bad_hold = 0; holding = 1'b0; held = 8'h00;
    do_reset();
    tick();
    prev_req = tx_req;
    in_data = words[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && dones < 4; cyc++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        checks++; if (tx_data !== words[acc_idx]) begin errors++; $display("FAIL b2b_capture%0d: got %h want %h", acc_idx, tx_data, words[acc_idx]); end
        acc_idx++;
        if (acc_idx < 4) in_data = words[acc_idx];
        else in_valid = 1'b0;
      end
      if (tx_req !== prev_req) begin
        if (tx_data !== words[toggles]) bad_hold++;
        toggles++; holding = 1'b1; held = tx_data; prev_req = tx_req;
        tx_ack = tx_req;
      end else if (holding && tx_data !== held) begin
        bad_hold++;
      end
      if (done) begin
        dones++; holding = 1'b0;
      end
    end
    checks++; if (dones !== 4) begin errors++; $display("FAIL b2b_done_count: got %0d want 4", dones); end
    checks++; if (toggles !== 4) begin errors++; $display("FAIL b2b_req_toggles: got %0d want 4", toggles); end
    checks++; if (acc_idx !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d want 4", acc_idx); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL b2b_final_req: got %b want 0", tx_req); end
    checks++; if (bad_hold !== 0) begin errors++; $display("FAIL b2b_data_stable: got %0d unstable cycles want 0", bad_hold); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", err); end
  endtask

  task automatic test_timeout();
    do_reset();
    tick();
    in_data = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL to_req: got %b want 1", tx_req); end
    repeat (7) tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_wait7: got %b want 0", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_wait8: got %b want 1", err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL to_in_ready: got %b want 0", in_ready); end
    repeat (3) tick();
    checks++; if (in_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL to_still_wait: got in_ready=%b done=%b want 0 0", in_ready, done); end
    checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL to_tx_data: got %h want 5a", tx_data); end
    tx_ack = 1'b1;
    tick(); tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_done_early: got %b want 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL to_late_done: got %b want 1", done); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clr: got %b want 0", err); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_stays_clr: got %b want 0", err); end
  endtask

  task automatic test_spurious_ack();
    do_reset();
    tick();
    tx_ack = 1'b1;
    tick(); tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sp_err_early: got %b want 0", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sp_err_set: got %b want 1", err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sp_in_ready: got %b want 1", in_ready); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sp_clr_priority: got %b want 0", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sp_err_reset_again: got %b want 1", err); end
    tx_ack = 1'b0;
    repeat (2) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sp_err_recovered: got %b want 0", err); end
  endtask

  task automatic test_mid_reset();
    int bad;
    bad = 0;
    do_reset();
    tick();
    in_data = 8'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL mr_in_wait: got %b want 1", tx_req); end
    #2;
    rst_n = 1'b0; tx_ack = 1'b0;
    #1;
    checks++; if (tx_req !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mr_async_req_data: got %b %h want 0 00", tx_req, tx_data); end
    checks++; if (in_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mr_async_flags: got %b%b%b want 000", in_ready, done, err); end
    repeat (3) begin
      tick();
      if (done !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mr_quiet_in_reset: got %0d bad cycles want 0", bad); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_ready_after: got %b want 1", in_ready); end
    in_data = 8'h3C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (tx_data !== 8'h3C) begin errors++; $display("FAIL mr_tx_data: got %h want 3c", tx_data); end
    tick(); tick();
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL mr_req: got %b want 1", tx_req); end
    tx_ack = 1'b1;
    tick(); tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mr_done: got %b want 1", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mr_err: got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_timeout();
    test_spurious_ack();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
